// File: rtl/ksa_ctrl_fsm.sv
// RC4 key-scheduling initiator: walks i over the S array, accumulates j and requests s[i]/s[j] swaps.
// Define KSA_SWAP_TIMEOUT_EN to add a swap-engine timeout that parks the FSM in ERR with err raised.
module ksa_ctrl_fsm #(
  parameter int KEY_BYTES = 3
`ifdef KSA_SWAP_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             mem_addr,
  input  logic [7:0]             mem_q,
  output logic                   swap_flag,
  output logic [7:0]             counter_i,
  output logic [7:0]             counter_j,
  input  logic                   swap_done,
  output logic                   done,
  output logic                   busy,
  output logic                   err
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_SI,
    WAIT_SI,
    CALC_J,
    SWAP_REQ,
    DONE_ST
`ifdef KSA_SWAP_TIMEOUT_EN
    , ERR_ST
`endif
  } state_t;

  state_t            state_q;
  logic [7:0]        i_q;
  logic [7:0]        j_q;
  logic [KIDX_W-1:0] kidx_q;
  logic              swap_flag_q;
  logic [7:0]        counter_i_q;
  logic [7:0]        counter_j_q;
  logic              done_q;
  logic              busy_q;
  logic [7:0]        j_d;

  // Key byte 0 sits in the most significant byte of the key bus.
  logic [7:0] key_byte [KEY_BYTES];
  generate
    for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key_byte
      assign key_byte[gi] = key[8*(KEY_BYTES-1-gi) +: 8];
    end
  endgenerate

  assign j_d = j_q + mem_q + key_byte[kidx_q];

`ifdef KSA_SWAP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      kidx_q      <= '0;
      swap_flag_q <= 1'b0;
      counter_i_q <= 8'd0;
      counter_j_q <= 8'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef KSA_SWAP_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            kidx_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RD_SI;
          end
        end
        RD_SI:   state_q <= WAIT_SI;
        WAIT_SI: state_q <= CALC_J;
        CALC_J: begin
          j_q         <= j_d;
          counter_i_q <= i_q;
          counter_j_q <= j_d;
          swap_flag_q <= 1'b1;
`ifdef KSA_SWAP_TIMEOUT_EN
          tmo_q       <= '0;
`endif
          state_q     <= SWAP_REQ;
        end
        SWAP_REQ: begin
          // Advancing only on swap_done keeps the next s[i] read behind the swap write.
          if (swap_done) begin
            swap_flag_q <= 1'b0;
            if (i_q == 8'hFF) begin
              done_q  <= 1'b1;
              state_q <= DONE_ST;
            end else begin
              i_q     <= i_q + 8'd1;
              kidx_q  <= (kidx_q == KIDX_W'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
              state_q <= RD_SI;
            end
          end
`ifdef KSA_SWAP_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYCLES-1)) begin
            swap_flag_q <= 1'b0;
            err_q       <= 1'b1;
            state_q     <= ERR_ST;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        DONE_ST: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
`ifdef KSA_SWAP_TIMEOUT_EN
        ERR_ST: state_q <= ERR_ST;
`endif
        default: begin
          swap_flag_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = i_q;
  assign swap_flag = swap_flag_q;
  assign counter_i = counter_i_q;
  assign counter_j = counter_j_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule
